// File: rtl/fft_peak_pkg.sv
// Shared encodings for the FFT peak detector: magnitude modes, frame FSM states
// and the magnitude width helper.
package fft_peak_pkg;

   localparam int unsigned MAG_L1   = 0;
   localparam int unsigned MAG_AMBM = 1;
   localparam int unsigned MAG_L2   = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   // Wide enough for re^2 + im^2 with re = im = -2^(DW-1).
   function automatic int unsigned mag_width(input int unsigned dw);
      return 2 * dw + 1;
   endfunction

endpackage

// File: rtl/fft_mag_calc.sv
// One-stage registered magnitude unit: |re|,|im| then L1, alpha-max-beta-min
// or squared L2 magnitude selected at elaboration time.
module fft_mag_calc
   import fft_peak_pkg::*;
#(
   parameter int unsigned DW       = 16,
   parameter int unsigned MAG_MODE = MAG_L1,
   localparam int unsigned MW      = mag_width(DW)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_re,
   input  logic [DW-1:0] i_im,
   output logic [MW-1:0] o_mag
);

   logic [DW-1:0] w_abs_re;
   logic [DW-1:0] w_abs_im;
   logic [DW-1:0] w_max;
   logic [DW-1:0] w_min;
   logic [MW-1:0] w_mag;
   logic [MW-1:0] r_mag;

   // DW-bit unsigned result keeps |-2^(DW-1)| exact.
   assign w_abs_re = i_re[DW-1] ? (~i_re + 1'b1) : i_re;
   assign w_abs_im = i_im[DW-1] ? (~i_im + 1'b1) : i_im;

   assign w_max = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
   assign w_min = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;

   always_comb begin
      w_mag = '0;
      case (MAG_MODE)
         MAG_L1:   w_mag = MW'(w_abs_re) + MW'(w_abs_im);
         MAG_AMBM: w_mag = MW'(w_max) + MW'(w_min >> 1);
         default:  w_mag = MW'(w_abs_re) * MW'(w_abs_re) + MW'(w_abs_im) * MW'(w_abs_im);
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mag <= '0;
      end else if (i_valid) begin
         r_mag <= w_mag;
      end
   end

   assign o_mag = r_mag;

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming peak-bin detector: per-bin magnitude, windowed strict-max search,
// frame-sequence checking and a per-frame result strobe three cycles after s_last.
module fft_peak_detect
   import fft_peak_pkg::*;
#(
   parameter int unsigned DW       = 16,
   parameter int unsigned N_LOG2   = 10,
   parameter int unsigned BIN_LO   = 1,
   parameter int unsigned BIN_HI   = 511,
   parameter int unsigned MAG_MODE = 0,
   parameter int unsigned FS_HZ    = 1000000,
   parameter int unsigned FW       = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_s_valid,
   input  logic [2*DW-1:0]   i_s_data,
   input  logic [N_LOG2-1:0] i_s_index,
   input  logic              i_s_last,
   input  logic [2*DW:0]     i_cfg_threshold,
   output logic              o_peak_valid,
   output logic              o_peak_found,
   output logic [N_LOG2-1:0] o_peak_index,
   output logic [2*DW:0]     o_peak_mag,
   output logic [DW-1:0]     o_peak_re,
   output logic [DW-1:0]     o_peak_im,
   output logic [FW-1:0]     o_peak_freq,
   output logic              o_frame_err
);

   localparam int unsigned MW = mag_width(DW);
   localparam int unsigned PW = N_LOG2 + 32;
   localparam logic [N_LOG2-1:0] LAST_IDX = '1;
   localparam logic [N_LOG2-1:0] LO_IDX   = N_LOG2'(BIN_LO);
   localparam logic [N_LOG2-1:0] HI_IDX   = N_LOG2'(BIN_HI);

   logic [DW-1:0] w_re;
   logic [DW-1:0] w_im;
   assign w_re = i_s_data[2*DW-1:DW];
   assign w_im = i_s_data[DW-1:0];

   // ---------------- frame FSM ----------------
   state_e            r_state;
   logic [N_LOG2-1:0] r_exp;
   logic              r_err;
   logic [N_LOG2-1:0] w_exp;
   logic              w_frame_err;

   assign w_exp = (r_state == ACTIVE) ? r_exp : '0;
   // Last beat must sit on N-1, and reaching N-1 without last is a wrap.
   assign w_frame_err = ((r_state == ACTIVE) && r_err) || (i_s_index != w_exp) ||
                        (i_s_last != (i_s_index == LAST_IDX));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_exp   <= '0;
         r_err   <= 1'b0;
      end else if (i_s_valid) begin
         if (i_s_last) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_err   <= 1'b0;
         end else begin
            r_state <= ACTIVE;
            r_exp   <= i_s_index + 1'b1;
            r_err   <= w_frame_err;
         end
      end
   end

   // ---------------- stage 1 ----------------
   logic [MW-1:0]     w_s1_mag;
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [N_LOG2-1:0] r_s1_index;
   logic [DW-1:0]     r_s1_re;
   logic [DW-1:0]     r_s1_im;
   logic              r_s1_err;
   logic [MW-1:0]     r_s1_thr;

   fft_mag_calc #(
      .DW       (DW),
      .MAG_MODE (MAG_MODE)
   ) u_mag (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_s_valid),
      .i_re    (w_re),
      .i_im    (w_im),
      .o_mag   (w_s1_mag)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_index <= '0;
         r_s1_re    <= '0;
         r_s1_im    <= '0;
         r_s1_err   <= 1'b0;
         r_s1_thr   <= '0;
      end else begin
         r_s1_valid <= i_s_valid;
         if (i_s_valid) begin
            r_s1_last  <= i_s_last;
            r_s1_index <= i_s_index;
            r_s1_re    <= w_re;
            r_s1_im    <= w_im;
            r_s1_err   <= w_frame_err;
            if (i_s_last) begin
               r_s1_thr <= i_cfg_threshold;
            end
         end
      end
   end

   // ---------------- stage 2: windowed search ----------------
   logic              w_in_win;
   logic [MW-1:0]     w_nx_mag;
   logic [N_LOG2-1:0] w_nx_index;
   logic [DW-1:0]     w_nx_re;
   logic [DW-1:0]     w_nx_im;
   logic              w_nx_inwin;
   logic [MW-1:0]     r_best_mag;
   logic [N_LOG2-1:0] r_best_index;
   logic [DW-1:0]     r_best_re;
   logic [DW-1:0]     r_best_im;
   logic              r_best_inwin;

   assign w_in_win = (r_s1_index >= LO_IDX) && (r_s1_index <= HI_IDX);

   always_comb begin
      w_nx_mag   = r_best_mag;
      w_nx_index = r_best_index;
      w_nx_re    = r_best_re;
      w_nx_im    = r_best_im;
      w_nx_inwin = r_best_inwin;
      if (r_s1_valid && w_in_win) begin
         w_nx_inwin = 1'b1;
         // Strict compare keeps the lowest index on ties.
         if (w_s1_mag > r_best_mag) begin
            w_nx_mag   = w_s1_mag;
            w_nx_index = r_s1_index;
            w_nx_re    = r_s1_re;
            w_nx_im    = r_s1_im;
         end
      end
   end

   logic              r_res_pend;
   logic [MW-1:0]     r_res_mag;
   logic [N_LOG2-1:0] r_res_index;
   logic [DW-1:0]     r_res_re;
   logic [DW-1:0]     r_res_im;
   logic              r_res_inwin;
   logic              r_res_err;
   logic [MW-1:0]     r_res_thr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_best_mag   <= '0;
         r_best_index <= '0;
         r_best_re    <= '0;
         r_best_im    <= '0;
         r_best_inwin <= 1'b0;
         r_res_pend   <= 1'b0;
         r_res_mag    <= '0;
         r_res_index  <= '0;
         r_res_re     <= '0;
         r_res_im     <= '0;
         r_res_inwin  <= 1'b0;
         r_res_err    <= 1'b0;
         r_res_thr    <= '0;
      end else begin
         r_res_pend <= 1'b0;
         if (r_s1_valid && r_s1_last) begin
            r_res_pend   <= 1'b1;
            r_res_mag    <= w_nx_mag;
            r_res_index  <= w_nx_index;
            r_res_re     <= w_nx_re;
            r_res_im     <= w_nx_im;
            r_res_inwin  <= w_nx_inwin;
            r_res_err    <= r_s1_err;
            r_res_thr    <= r_s1_thr;
            r_best_mag   <= '0;
            r_best_index <= '0;
            r_best_re    <= '0;
            r_best_im    <= '0;
            r_best_inwin <= 1'b0;
         end else begin
            r_best_mag   <= w_nx_mag;
            r_best_index <= w_nx_index;
            r_best_re    <= w_nx_re;
            r_best_im    <= w_nx_im;
            r_best_inwin <= w_nx_inwin;
         end
      end
   end

   // ---------------- output stage with frequency multiply ----------------
   logic [PW-1:0]     w_prod;
   logic              r_pk_valid;
   logic              r_pk_found;
   logic [N_LOG2-1:0] r_pk_index;
   logic [MW-1:0]     r_pk_mag;
   logic [DW-1:0]     r_pk_re;
   logic [DW-1:0]     r_pk_im;
   logic [FW-1:0]     r_pk_freq;
   logic              r_pk_err;

   assign w_prod = PW'(r_res_index) * PW'(FS_HZ);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pk_valid <= 1'b0;
         r_pk_found <= 1'b0;
         r_pk_index <= '0;
         r_pk_mag   <= '0;
         r_pk_re    <= '0;
         r_pk_im    <= '0;
         r_pk_freq  <= '0;
         r_pk_err   <= 1'b0;
      end else begin
         r_pk_valid <= r_res_pend;
         if (r_res_pend) begin
            r_pk_found <= r_res_inwin && (r_res_mag >= r_res_thr);
            r_pk_index <= r_res_index;
            r_pk_mag   <= r_res_mag;
            r_pk_re    <= r_res_re;
            r_pk_im    <= r_res_im;
            r_pk_freq  <= FW'(w_prod >> N_LOG2);
            r_pk_err   <= r_res_err;
         end
      end
   end

   assign o_peak_valid = r_pk_valid;
   assign o_peak_found = r_pk_found;
   assign o_peak_index = r_pk_index;
   assign o_peak_mag   = r_pk_mag;
   assign o_peak_re    = r_pk_re;
   assign o_peak_im    = r_pk_im;
   assign o_peak_freq  = r_pk_freq;
   assign o_frame_err  = r_pk_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: three instances (one per magnitude mode)
// share stimulus; a monitor logs every strobe and the main sequence checks them.
module tb_fft_peak_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic [31:0] s_data;
   logic [9:0]  s_index;
   logic        s_last;
   logic [32:0] thr_in;

   logic        pv     [3];
   logic        pfound [3];
   logic [9:0]  pidx   [3];
   logic [32:0] pmag   [3];
   logic [15:0] pre    [3];
   logic [15:0] pim    [3];
   logic [31:0] pfreq  [3];
   logic        perr   [3];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fft_peak_detect #(.MAG_MODE(g)) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_s_valid       (s_valid),
         .i_s_data        (s_data),
         .i_s_index       (s_index),
         .i_s_last        (s_last),
         .i_cfg_threshold (thr_in),
         .o_peak_valid    (pv[g]),
         .o_peak_found    (pfound[g]),
         .o_peak_index    (pidx[g]),
         .o_peak_mag      (pmag[g]),
         .o_peak_re       (pre[g]),
         .o_peak_im       (pim[g]),
         .o_peak_freq     (pfreq[g]),
         .o_frame_err     (perr[g])
      );
   end

   typedef struct {
      longint cyc;
      longint idx;
      longint mag;
      longint re;
      longint im;
      longint freq;
      longint found;
      longint err;
   } snap_t;

   snap_t q0[$];
   snap_t q1[$];
   snap_t q2[$];

   logic signed [15:0] re_a [1024];
   logic signed [15:0] im_a [1024];

   function automatic snap_t mk(input int k);
      snap_t s;
      s.cyc   = 64'(cyc);
      s.idx   = 64'(pidx[k]);
      s.mag   = 64'(pmag[k]);
      s.re    = 64'($signed(pre[k]));
      s.im    = 64'($signed(pim[k]));
      s.freq  = 64'(pfreq[k]);
      s.found = 64'(pfound[k]);
      s.err   = 64'(perr[k]);
      return s;
   endfunction

   always @(negedge clk) begin
      if (pv[0]) q0.push_back(mk(0));
      if (pv[1]) q1.push_back(mk(1));
      if (pv[2]) q2.push_back(mk(2));
   end

   function automatic snap_t empty_snap();
      snap_t s;
      s = '{default: -1};
      return s;
   endfunction

   function automatic snap_t pop0();
      return (q0.size() > 0) ? q0.pop_front() : empty_snap();
   endfunction
   function automatic snap_t pop1();
      return (q1.size() > 0) ? q1.pop_front() : empty_snap();
   endfunction
   function automatic snap_t pop2();
      return (q2.size() > 0) ? q2.pop_front() : empty_snap();
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_bg();
      for (int i = 0; i < 1024; i++) begin
         re_a[i] = 16'sd1;
         im_a[i] = 16'sd1;
      end
   endtask

   task automatic set_bin(input int i, input int re, input int im);
      re_a[i] = 16'(re);
      im_a[i] = 16'(im);
   endtask

   task automatic clear_q();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // Drives indices first..last (minus skip); rst pulses together with beat rst_at.
   task automatic run_frame(input int first, input int last, input int skip,
                            input int rst_at, input int thr, output int tl);
      tl = -1;
      for (int i = first; i <= last; i++) begin
         if (i == skip) continue;
         @(negedge clk);
         s_valid = 1'b1;
         s_index = 10'(i);
         s_data  = {re_a[i], im_a[i]};
         s_last  = (i == last);
         thr_in  = 33'(thr);
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst     = 1'b0;
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         if (i == last) tl = cyc;
      end
   endtask

   task automatic finish_frame();
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, 64'(pv[0]), 0);
      chk({tag, "_found"}, 64'(pfound[0]), 0);
      chk({tag, "_idx"}, 64'(pidx[0]), 0);
      chk({tag, "_mag"}, 64'(pmag[0]), 0);
      chk({tag, "_re"}, 64'(pre[0]), 0);
      chk({tag, "_im"}, 64'(pim[0]), 0);
      chk({tag, "_freq"}, 64'(pfreq[0]), 0);
      chk({tag, "_err"}, 64'(perr[0]), 0);
   endtask

   initial begin
      snap_t s;
      snap_t s2;
      int tl;
      int tl2;

      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_index = '0;
      s_last  = 1'b0;
      thr_in  = '0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single tone at bin 100.
      set_bg();
      set_bin(100, 1000, -500);
      clear_q();
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      chk("tone_count", 64'(q0.size()), 1);
      s = pop0();
      chk("tone_cyc", s.cyc, 64'(tl + 3));
      chk("tone_idx", s.idx, 100);
      chk("tone_mag", s.mag, 1500);
      chk("tone_re", s.re, 1000);
      chk("tone_im", s.im, -500);
      chk("tone_freq", s.freq, 97656);
      chk("tone_found", s.found, 1);
      chk("tone_err", s.err, 0);
      s = pop1();
      chk("tone_m1_mag", s.mag, 1250);
      s = pop2();
      chk("tone_m2_mag", s.mag, 1250000);

      // Tie between bins 5 and 9, larger bin 600 outside the window.
      set_bg();
      set_bin(5, 800, 0);
      set_bin(9, 400, -400);
      set_bin(600, 5000, 0);
      clear_q();
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("tie_idx", s.idx, 5);
      chk("tie_mag", s.mag, 800);
      chk("tie_re", s.re, 800);
      chk("tie_freq", s.freq, 4882);

      // Most negative component.
      set_bg();
      set_bin(10, -32768, 0);
      clear_q();
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("neg_m0_mag", s.mag, 32768);
      chk("neg_m0_re", s.re, -32768);
      chk("neg_m0_idx", s.idx, 10);
      s = pop1();
      chk("neg_m1_mag", s.mag, 32768);
      s = pop2();
      chk("neg_m2_mag", s.mag, 1073741824);

      // {3,4} in each mode.
      set_bg();
      set_bin(20, 3, 4);
      clear_q();
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("b34_m0_mag", s.mag, 7);
      s = pop1();
      chk("b34_m1_mag", s.mag, 5);
      s = pop2();
      chk("b34_m2_mag", s.mag, 25);
      chk("b34_m2_idx", s.idx, 20);

      // Skipped index 50, then a clean frame, then s_last at 700.
      set_bg();
      clear_q();
      run_frame(0, 1023, 50, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("skip_err", s.err, 1);
      chk("skip_idx", s.idx, 1);
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("clean_err", s.err, 0);
      run_frame(0, 700, -1, -1, 0, tl);
      finish_frame();
      chk("short_count", 64'(q0.size()), 1);
      s = pop0();
      chk("short_err", s.err, 1);

      // Only out-of-window indices.
      set_bin(600, 5000, 0);
      clear_q();
      run_frame(512, 1023, -1, -1, 0, tl);
      finish_frame();
      s = pop0();
      chk("nowin_found", s.found, 0);
      chk("nowin_idx", s.idx, 0);
      chk("nowin_mag", s.mag, 0);
      chk("nowin_re", s.re, 0);
      chk("nowin_im", s.im, 0);
      chk("nowin_freq", s.freq, 0);
      chk("nowin_err", s.err, 1);

      // Threshold boundary on back-to-back frames.
      set_bg();
      set_bin(100, 1000, -500);
      clear_q();
      run_frame(0, 1023, -1, -1, 2000, tl);
      run_frame(0, 1023, -1, -1, 1500, tl2);
      finish_frame();
      chk("b2b_count", 64'(q0.size()), 2);
      s  = pop0();
      s2 = pop0();
      chk("b2b_cyc1", s.cyc, 64'(tl + 3));
      chk("b2b_gap", s2.cyc - s.cyc, 1024);
      chk("b2b_found1", s.found, 0);
      chk("b2b_idx1", s.idx, 100);
      chk("b2b_found2", s2.found, 1);
      chk("b2b_idx2", s2.idx, 100);
      chk("b2b_mag2", s2.mag, 1500);
      chk("b2b_err2", s2.err, 0);

      // Reset at beat 300 discards the frame.
      clear_q();
      run_frame(0, 1023, -1, 300, 0, tl);
      repeat (6) @(negedge clk);
      chk("rstmid_count", 64'(q0.size()), 0);
      chk_zero_outputs("rstmid");
      run_frame(0, 1023, -1, -1, 0, tl);
      finish_frame();
      chk("after_count", 64'(q0.size()), 1);
      s = pop0();
      chk("after_cyc", s.cyc, 64'(tl + 3));
      chk("after_idx", s.idx, 100);
      chk("after_mag", s.mag, 1500);
      chk("after_found", s.found, 1);
      chk("after_err", s.err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
Streaming peak-bin detector for complex FFT output frames, the generalised successor of the team's fixed 1024-point max finder. It takes one {re,im} bin per valid beat and computes a selectable magnitude per bin. It tracks the largest magnitude inside a programmable bin window and, once per frame, reports the peak index, magnitude, raw re/im, the frequency in Hz, a threshold flag and a framing-error flag. It sits directly after the FFT core and accepts back-to-back frames without backpressure.

Parameters:
DW, 16, signed width of re and of im
N_LOG2, 10, log2 of the FFT length (N = 2^N_LOG2 bins per frame)
BIN_LO, 1, lowest bin index searched (inclusive; default skips DC)
BIN_HI, 511, highest bin index searched (inclusive; requires BIN_LO <= BIN_HI <= N-1)
MAG_MODE, 0, magnitude mode: 0 = |re|+|im|; 1 = max+min/2; 2 = re^2+im^2
FS_HZ, 1000000, sample rate in Hz used for the frequency output
FW, 32, width of peak_freq

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  bin beat valid; no ready, so every beat is accepted
s_data  in  2*DW  {re[2DW-1:DW], im[DW-1:0]}, two's complement
s_index  in  N_LOG2  bin index of the beat
s_last  in  1  final beat of the frame, qualified by s_valid
cfg_threshold  in  2*DW+1  minimum magnitude for peak_found; sampled on the s_last beat
peak_valid  out  1  one-cycle result strobe
peak_found  out  1  peak magnitude >= threshold
peak_index  out  N_LOG2  index of the peak bin
peak_mag  out  2*DW+1  magnitude of the peak bin, zero-extended
peak_re  out  DW  raw re of the peak bin
peak_im  out  DW  raw im of the peak bin
peak_freq  out  FW  (peak_index*FS_HZ) >> N_LOG2, truncated
frame_err  out  1  framing error detected in the reported frame

Behaviour:
- Reset: the synchronous active-high rst clears every output and all internal state to 0 and puts the frame FSM in IDLE. Asserting rst mid-frame discards the partial frame and any pending result; no peak_valid is produced for it.
- Abs: each component is converted to a DW-bit unsigned value. |-2^(DW-1)| = 2^(DW-1) is exact, with no saturation.
- Magnitude (width MW = 2*DW+1, computed in stage 1 and registered):
  - Mode 0: |re|+|im|.
  - Mode 1: max + (min>>1), with min>>1 truncated.
  - Mode 2: re*re + im*im.
- Frame FSM:
  - IDLE -> ACTIVE on any s_valid. An expected counter tracks the next index, starting at 0.
  - In ACTIVE, every beat compares s_index against the expected counter. A mismatch sets a sticky err bit. The counter then loads s_index+1, so later beats are checked relative to the actual index.
  - s_last with s_index != N-1 sets err.
  - If the counter wraps past N-1 without s_last, err is set and the frame continues until s_last.
  - The s_last beat returns the FSM to IDLE. A new frame may begin on the very next cycle, and the accumulator clears for it with no gap.
- Search (stage 2): for beats whose s_index is in [BIN_LO, BIN_HI], the running best updates when mag > best_mag (strict). Ties therefore keep the lowest index. An in-window flag records that at least one bin fell inside the window.
- Result path: on the cycle after the s_last beat is in stage 2, the best index, mag, re, im, in-window flag, err and the sampled threshold are copied into a result stage. This frees the accumulator for the next frame.
- Frequency: one registered multiply stage, peak_index*FS_HZ held at full width, then >> N_LOG2 and truncated to FW.
- Latency: if the s_last beat is accepted in cycle T, peak_valid is high for exactly cycle T+3. All peak_* outputs and frame_err hold their values until the next strobe.
- peak_found = in-window AND peak_mag >= threshold.
- No in-window beats: peak_found=0, peak_index=0, peak_mag=0, peak_re=0, peak_im=0, peak_freq=0.
- Minimum frame spacing is one cycle, i.e. s_last on consecutive frames may be N cycles apart. The three-stage result pipeline never overlaps because N >= 4 is required.

Decomposition:
- Package fft_peak_pkg: MAG_MODE encodings (MAG_L1, MAG_AMBM, MAG_L2), the FSM state enum {IDLE, ACTIVE}, and a function computing MW from DW.
- Sub-module fft_mag_calc: DW and MAG_MODE parameters; a one-stage registered abs-and-magnitude unit. It is reused by the planned multi-peak block.

Test Plan:
- Single tone: defaults, bin 100 = {re=1000, im=-500}, all other bins {1,1}, contiguous indices 0..1023 with s_last on 1023, threshold 0. Require peak_valid at T+3, peak_index=100, peak_mag=1500, peak_re=1000, peak_im=-500, peak_freq=97656, found=1, err=0.
- Tie and window: bins 5 and 9 both mag 800, bin 600 mag 5000 (outside BIN_HI=511). Require peak_index=5, peak_mag=800.
- Modes with bin {-32768, 0}: mode 0 gives mag 32768; mode 1 gives 32768; with bin {3,4} in mode 2, mag=25.
- Framing: skip index 50 (beats 49 then 51) -> frame_err=1, counter resyncs. Next frame clean -> frame_err=0. A separate frame with s_last at index 700 -> frame_err=1.
- Threshold and back-to-back: threshold 2000 with a peak of 1500 -> found=0, peak_index=100. A second frame starts the cycle after s_last -> two strobes exactly 1024 cycles apart, each with correct results.
- Reset mid-frame: assert rst for 1 cycle at beat 300 -> all outputs 0 and no peak_valid. A fresh frame afterwards is reported correctly with err=0.
